pm_loader: RTL and testbench



---
 rtl/pm_loader.sv | 179 +++++++++++++++++
 tb/tb_pm_loader.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/pm_loader.sv
// pm_loader: boot-time loader that writes a framed byte stream into program
// memory and holds cpu_core in reset until a checksummed frame has landed.
//
// Ports:
//   clock, reset_n      system clock, asynchronous active-low reset
//   in_valid, in_data   byte stream in; in_ready back-pressures the sender
//   pm_we, pm_addr,     one-cycle write strobe with address and 16-bit word
//   pm_wdata
//   core_reset          active-high reset to cpu_core
//   done, error         frame accepted / last frame rejected
//   words_loaded        words written in the current or most recent frame
module pm_loader #(
    parameter int          PM_DEPTH = 32,
    parameter logic [7:0]  HDR      = 8'hA5
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        pm_we,
    output logic [4:0]  pm_addr,
    output logic [15:0] pm_wdata,
    output logic        core_reset,
    output logic        done,
    output logic        error,
    output logic [5:0]  words_loaded
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_COUNT,
        S_HI,
        S_LO,
        S_WRITE,
        S_CHECK,
        S_RUN,
        S_ERR
    } state_t;

    localparam logic [7:0] MAX_N  = 8'(PM_DEPTH);
    localparam logic [5:0] WL_MAX = 6'(PM_DEPTH);

    state_t      state, state_d;
    logic [5:0]  n_q, n_d;
    logic [5:0]  idx_q, idx_d;
    logic [7:0]  hi_q, hi_d;
    logic [7:0]  chk_q, chk_d;

    logic        in_ready_d;
    logic        pm_we_d;
    logic [4:0]  pm_addr_d;
    logic [15:0] pm_wdata_d;
    logic        core_reset_d;
    logic        done_d;
    logic        error_d;
    logic [5:0]  words_loaded_d;

    logic        xfer;

    // in_ready is registered and mirrors "not in WRITE", so it is a
    // valid acceptance qualifier for the current cycle.
    assign xfer = in_valid && in_ready;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state        <= S_IDLE;
            n_q          <= '0;
            idx_q        <= '0;
            hi_q         <= '0;
            chk_q        <= '0;
            in_ready     <= 1'b1;
            pm_we        <= 1'b0;
            pm_addr      <= '0;
            pm_wdata     <= '0;
            core_reset   <= 1'b1;
            done         <= 1'b0;
            error        <= 1'b0;
            words_loaded <= '0;
        end else begin
            state        <= state_d;
            n_q          <= n_d;
            idx_q        <= idx_d;
            hi_q         <= hi_d;
            chk_q        <= chk_d;
            in_ready     <= in_ready_d;
            pm_we        <= pm_we_d;
            pm_addr      <= pm_addr_d;
            pm_wdata     <= pm_wdata_d;
            core_reset   <= core_reset_d;
            done         <= done_d;
            error        <= error_d;
            words_loaded <= words_loaded_d;
        end
    end

    always_comb begin
        state_d        = state;
        n_d            = n_q;
        idx_d          = idx_q;
        hi_d           = hi_q;
        chk_d          = chk_q;
        pm_addr_d      = pm_addr;
        pm_wdata_d     = pm_wdata;
        core_reset_d   = core_reset;
        done_d         = done;
        error_d        = error;
        words_loaded_d = words_loaded;

        unique case (state)
            S_IDLE, S_RUN, S_ERR: begin
                if (xfer && in_data == HDR) begin
                    state_d        = S_COUNT;
                    core_reset_d   = 1'b1;
                    done_d         = 1'b0;
                    error_d        = 1'b0;
                    words_loaded_d = '0;
                    idx_d          = '0;
                    chk_d          = '0;
                end
            end
            S_COUNT: begin
                if (xfer) begin
                    if (in_data == 8'd0 || in_data > MAX_N) begin
                        state_d = S_ERR;
                        error_d = 1'b1;
                    end else begin
                        n_d     = in_data[5:0];
                        chk_d   = chk_q ^ in_data;
                        state_d = S_HI;
                    end
                end
            end
            S_HI: begin
                if (xfer) begin
                    hi_d    = in_data;
                    chk_d   = chk_q ^ in_data;
                    state_d = S_LO;
                end
            end
            S_LO: begin
                if (xfer) begin
                    chk_d      = chk_q ^ in_data;
                    pm_addr_d  = idx_q[4:0];
                    pm_wdata_d = {hi_q, in_data};
                    state_d    = S_WRITE;
                end
            end
            S_WRITE: begin
                idx_d = idx_q + 6'd1;
                if (words_loaded != WL_MAX)
                    words_loaded_d = words_loaded + 6'd1;
                if (idx_q + 6'd1 == n_q)
                    state_d = S_CHECK;
                else
                    state_d = S_HI;
            end
            S_CHECK: begin
                if (xfer) begin
                    if (in_data == chk_q) begin
                        state_d      = S_RUN;
                        done_d       = 1'b1;
                        core_reset_d = 1'b0;
                    end else begin
                        state_d = S_ERR;
                        error_d = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // The write strobe and the ready drop both belong to the WRITE
        // cycle, so they are registered from the upcoming state.
        in_ready_d = (state_d != S_WRITE);
        pm_we_d    = (state_d == S_WRITE);
    end

endmodule

// File: tb/tb_pm_loader.sv
// tb_pm_loader: randomized frame-level bench for pm_loader with a
// program-memory reference model and per-frame outcome prediction.
module tb_pm_loader;

    localparam logic [7:0] HDR = 8'hA5;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        pm_we;
    logic [4:0]  pm_addr;
    logic [15:0] pm_wdata;
    logic        core_reset;
    logic        done;
    logic        error;
    logic [5:0]  words_loaded;

    int          errs = 0;
    int          checks = 0;
    int          cyc = 0;
    int          wr_count = 0;
    int          last_acc = 0;

    logic [15:0] tb_mem[32];
    logic [15:0] ref_mem[32];
    logic [15:0] frame_words[32];

    pm_loader dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .pm_we        (pm_we),
        .pm_addr      (pm_addr),
        .pm_wdata     (pm_wdata),
        .core_reset   (core_reset),
        .done         (done),
        .error        (error),
        .words_loaded (words_loaded)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc++;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Program memory as cpu_core would see it.
    always @(negedge clock) begin
        if (reset_n && pm_we) begin
            tb_mem[pm_addr] = pm_wdata;
            wr_count++;
            check("we_rdy", {31'd0, in_ready}, 32'd0);
        end
    end

    task automatic send_byte(input logic [7:0] b, input int gap);
        bit acc;
        for (int g = 0; g < 3; g++) begin
            if (gap > 0 && $urandom_range(99) < gap) begin
                in_valid = 1'b0;
                in_data  = 8'($urandom);
                @(posedge clock); #1;
            end
        end
        in_valid = 1'b1;
        in_data  = b;
        acc      = 1'b0;
        for (int k = 0; k < 50 && !acc; k++) begin
            acc = in_ready;
            @(posedge clock); #1;
        end
        in_valid = 1'b0;
        last_acc = cyc;
        check("accept", {31'd0, acc}, 32'd1);
    endtask

    task automatic fill_random(input int n);
        for (int i = 0; i < n; i++) frame_words[i] = 16'($urandom);
    endtask

    task automatic check_mem();
        for (int i = 0; i < 32; i++)
            check($sformatf("mem%0d", i), {16'd0, tb_mem[i]},
                  {16'd0, ref_mem[i]});
    endtask

    task automatic check_reset_vals();
        check("rst_rdy",  {31'd0, in_ready},   32'd1);
        check("rst_we",   {31'd0, pm_we},      32'd0);
        check("rst_addr", {27'd0, pm_addr},    32'd0);
        check("rst_wd",   {16'd0, pm_wdata},   32'd0);
        check("rst_crst", {31'd0, core_reset}, 32'd1);
        check("rst_done", {31'd0, done},       32'd0);
        check("rst_err",  {31'd0, error},      32'd0);
        check("rst_wl",   {26'd0, words_loaded}, 32'd0);
    endtask

    // Sends HDR, N, the words in frame_words and the checksum, then
    // checks the outcome predicted from the frame rules.
    task automatic load_frame(input int n, input bit bad, input int gap);
        bit         n_ok;
        bit         ok;
        logic [7:0] c;
        int         t0;
        int         exp_n;
        n_ok     = (n >= 1 && n <= 32);
        wr_count = 0;
        send_byte(HDR, gap);
        t0 = last_acc;
        check("hdr_crst", {31'd0, core_reset}, 32'd1);
        check("hdr_done", {31'd0, done},       32'd0);
        send_byte(8'(n), gap);
        ok = 1'b0;
        if (n_ok) begin
            c = 8'(n);
            for (int i = 0; i < n; i++) begin
                send_byte(frame_words[i][15:8], gap);
                send_byte(frame_words[i][7:0], gap);
                c = c ^ frame_words[i][15:8] ^ frame_words[i][7:0];
                ref_mem[i] = frame_words[i];
            end
            check("pre_crst", {31'd0, core_reset}, 32'd1);
            check("pre_done", {31'd0, done},       32'd0);
            send_byte(bad ? ~c : c, gap);
            if (gap == 0)
                check("frame_len", last_acc - t0, 3 * n + 2);
            ok = !bad;
        end
        exp_n = n_ok ? n : 0;
        check("done",  {31'd0, done},       {31'd0, ok});
        check("error", {31'd0, error},      {31'd0, !ok});
        check("crst",  {31'd0, core_reset}, {31'd0, !ok});
        check("wl",    {26'd0, words_loaded}, exp_n);
        check("wr_cnt", wr_count, exp_n);
        check("rdy",   {31'd0, in_ready},   32'd1);
        check_mem();
    endtask

    initial begin
        int n;
        int cnt_const;
        for (int i = 0; i < 32; i++) begin
            tb_mem[i]  = 16'hDEAD;
            ref_mem[i] = 16'hDEAD;
        end
        in_valid = 1'b0;
        in_data  = 8'h00;
        reset_n  = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check_reset_vals();
        #2 reset_n = 1'b1;
        @(posedge clock); #1;

        // Basic load
        frame_words[0] = 16'h1234;
        frame_words[1] = 16'h5678;
        frame_words[2] = 16'h9ABC;
        load_frame(3, 1'b0, 0);

        // Bad checksum, then recovery
        load_frame(3, 1'b1, 0);
        load_frame(3, 1'b0, 0);

        // Count bounds
        load_frame(0, 1'b0, 0);
        load_frame(33, 1'b0, 0);
        fill_random(32);
        load_frame(32, 1'b0, 0);
        check("last_addr", {27'd0, pm_addr}, 32'd31);

        // Handshake: same frame with and without gaps
        n = $urandom_range(5, 32);
        fill_random(n);
        load_frame(n, 1'b0, 0);
        cnt_const = wr_count;
        load_frame(n, 1'b0, 40);
        check("hs_cnt", wr_count, cnt_const);

        // Reload from RUN
        send_byte(8'h55, 0);
        check("r55_done", {31'd0, done},       32'd1);
        check("r55_crst", {31'd0, core_reset}, 32'd0);
        frame_words[0] = 16'h0007;
        load_frame(1, 1'b0, 0);

        // Async reset during the LO byte of word 2
        fill_random(4);
        send_byte(HDR, 0);
        send_byte(8'd4, 0);
        for (int i = 0; i < 2; i++) begin
            send_byte(frame_words[i][15:8], 0);
            send_byte(frame_words[i][7:0], 0);
            ref_mem[i] = frame_words[i];
        end
        send_byte(frame_words[2][15:8], 0);
        in_valid = 1'b1;
        in_data  = frame_words[2][7:0];
        #3 reset_n = 1'b0;
        #1;
        check_reset_vals();
        in_valid = 1'b0;
        @(posedge clock);
        #2 reset_n = 1'b1;
        @(posedge clock); #1;
        check_mem();
        fill_random(4);
        load_frame(4, 1'b0, 0);

        // Random frames
        for (int r = 0; r < 8; r++) begin
            n = $urandom_range(1, 32);
            fill_random(n);
            load_frame(n, ($urandom_range(3) == 0),
                       ($urandom_range(1) == 0) ? 0 : 30);
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
